// File: rtl/hidden_spike_buffer.sv
// hidden_spike_buffer: per-channel saturating spike-event counters feeding a
// downstream arbitrated request/acknowledge interface. A channel requests
// while it has pending events; each valid acknowledge consumes one event.
// Optional feature macro: HIDDEN_SPIKE_DROP_CNT_EN adds a 16-bit saturating
// drop_count output that totals every event lost to counter saturation.
module hidden_spike_buffer #(
    parameter int N_CH  = 8,
    parameter int CNT_W = 3
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic [N_CH-1:0] spike_in,
    input  logic [N_CH-1:0] acks_in,
    output logic [N_CH-1:0] spikes_out,
    output logic            pending_any,
    output logic            overflow
`ifdef HIDDEN_SPIKE_DROP_CNT_EN
    ,
    output logic [15:0]     drop_count
`endif
);

    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [N_CH-1:0][CNT_W-1:0] count_q;
    logic [N_CH-1:0][CNT_W-1:0] count_d;
    logic                       overflow_q;
    logic                       overflow_d;
    logic [N_CH-1:0]            drop_vec_s;
    logic [N_CH-1:0]            valid_ack_s;

    // Per-channel up/down counter next state; a spike arriving on a full
    // channel is dropped and flagged.
    always_comb begin
        count_d     = count_q;
        drop_vec_s  = {N_CH{1'b0}};
        valid_ack_s = {N_CH{1'b0}};
        for (int i = 0; i < N_CH; i++) begin
            valid_ack_s[i] = acks_in[i] & (count_q[i] != CNT_ZERO);
            case ({spike_in[i], valid_ack_s[i]})
                2'b10: begin
                    if (count_q[i] == CNT_MAX) begin
                        drop_vec_s[i] = 1'b1;
                    end else begin
                        count_d[i] = count_q[i] + CNT_ONE;
                    end
                end
                2'b01: begin
                    count_d[i] = count_q[i] - CNT_ONE;
                end
                default: begin
                    count_d[i] = count_q[i];
                end
            endcase
        end
        overflow_d = overflow_q | (|drop_vec_s);
    end

    // State registers; reset discards every pending event and the sticky flag.
    always_ff @(posedge clk) begin
        if (resetn) begin
            count_q    <= {(N_CH*CNT_W){1'b0}};
            overflow_q <= 1'b0;
        end else begin
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

`ifdef HIDDEN_SPIKE_DROP_CNT_EN
    localparam int DW = $clog2(N_CH + 1);

    logic [15:0]   drop_count_q;
    logic [15:0]   drop_count_d;
    logic [DW-1:0] drop_num_s;
    logic [16:0]   drop_sum_s;

    // Count dropped events this cycle and add them with saturation at 16'hFFFF.
    always_comb begin
        drop_num_s = {DW{1'b0}};
        for (int i = 0; i < N_CH; i++) begin
            drop_num_s = drop_num_s + DW'(drop_vec_s[i]);
        end
        drop_sum_s = {1'b0, drop_count_q} + 17'(drop_num_s);
        if (drop_sum_s[16]) begin
            drop_count_d = 16'hFFFF;
        end else begin
            drop_count_d = drop_sum_s[15:0];
        end
    end

    // Drop-count register, cleared only by reset.
    always_ff @(posedge clk) begin
        if (resetn) begin
            drop_count_q <= 16'h0000;
        end else begin
            drop_count_q <= drop_count_d;
        end
    end

    assign drop_count = drop_count_q;
`endif

    // Outputs decode registered state only, so a combinational downstream
    // acknowledge can never form a loop back through this block.
    always_comb begin
        spikes_out = {N_CH{1'b0}};
        for (int i = 0; i < N_CH; i++) begin
            spikes_out[i] = (count_q[i] != CNT_ZERO);
        end
        pending_any = |spikes_out;
        overflow    = overflow_q;
    end

endmodule

// File: tb/tb_hidden_spike_buffer.sv
// Scoreboard bench for hidden_spike_buffer: stimulus pushes the expected
// post-edge outputs into a queue, a negedge monitor pops and compares.
module tb_hidden_spike_buffer;

    logic       clk = 1'b0;
    logic       resetn = 1'b1;
    logic [7:0] spike_in = 8'h00;
    logic [7:0] acks_in = 8'h00;
    logic [7:0] spikes_out;
    logic       pending_any;
    logic       overflow;
`ifdef HIDDEN_SPIKE_DROP_CNT_EN
    logic [15:0] drop_count;
`endif

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [7:0]  sp;
        logic        ov;
        logic [15:0] dc;
    } exp_t;

    exp_t sb_q[$];

    hidden_spike_buffer #(.N_CH(8), .CNT_W(3)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .spike_in    (spike_in),
        .acks_in     (acks_in),
        .spikes_out  (spikes_out),
        .pending_any (pending_any),
        .overflow    (overflow)
`ifdef HIDDEN_SPIKE_DROP_CNT_EN
        ,
        .drop_count  (drop_count)
`endif
    );

    always #5 clk = ~clk;

    // Monitor: one expectation per clock, compared on the falling edge.
    always @(negedge clk) begin
        exp_t e;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            checks++;
            if (spikes_out !== e.sp) begin
                failures++;
                $display("FAIL spikes_out got=%h exp=%h t=%0t", spikes_out, e.sp, $time);
            end
            checks++;
            if (pending_any !== (|e.sp)) begin
                failures++;
                $display("FAIL pending_any got=%b exp=%b t=%0t", pending_any, |e.sp, $time);
            end
            checks++;
            if (overflow !== e.ov) begin
                failures++;
                $display("FAIL overflow got=%b exp=%b t=%0t", overflow, e.ov, $time);
            end
`ifdef HIDDEN_SPIKE_DROP_CNT_EN
            checks++;
            if (drop_count !== e.dc) begin
                failures++;
                $display("FAIL drop_count got=%h exp=%h t=%0t", drop_count, e.dc, $time);
            end
`endif
        end
    end

    // Apply one cycle of inputs and queue the outputs expected after the edge.
    task automatic step(input logic [7:0] sp, input logic [7:0] ak, input logic rst,
                        input logic [7:0] xs, input logic xo, input logic [15:0] xd);
        exp_t e;
        spike_in = sp;
        acks_in  = ak;
        resetn   = rst;
        @(posedge clk);
        e.sp = xs;
        e.ov = xo;
        e.dc = xd;
        sb_q.push_back(e);
        #1;
        spike_in = 8'h00;
        acks_in  = 8'h00;
        resetn   = 1'b0;
    endtask

    initial begin
        logic [7:0] ak;
        logic [7:0] xs;
        int         wait_cnt;

        // Reset for two cycles
        step(8'h00, 8'h00, 1'b1, 8'h00, 1'b0, 16'd0);
        step(8'h00, 8'h00, 1'b1, 8'h00, 1'b0, 16'd0);

        // Single event on channel 2, then acknowledged
        step(8'h04, 8'h00, 1'b0, 8'h04, 1'b0, 16'd0);
        step(8'h00, 8'h00, 1'b0, 8'h04, 1'b0, 16'd0);
        step(8'h00, 8'h04, 1'b0, 8'h00, 1'b0, 16'd0);
        step(8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 16'd0);

        // Accumulate three on channel 0, drain with held ack, then ack while empty
        for (int i = 0; i < 3; i++) step(8'h01, 8'h00, 1'b0, 8'h01, 1'b0, 16'd0);
        step(8'h00, 8'h01, 1'b0, 8'h01, 1'b0, 16'd0);
        step(8'h00, 8'h01, 1'b0, 8'h01, 1'b0, 16'd0);
        step(8'h00, 8'h01, 1'b0, 8'h00, 1'b0, 16'd0);
        step(8'h00, 8'h01, 1'b0, 8'h00, 1'b0, 16'd0);
        // One new event must drain with a single ack (no underflow happened)
        step(8'h01, 8'h00, 1'b0, 8'h01, 1'b0, 16'd0);
        step(8'h00, 8'h01, 1'b0, 8'h00, 1'b0, 16'd0);

        // Simultaneous spike and ack on channel 3 keeps count at 1
        step(8'h08, 8'h00, 1'b0, 8'h08, 1'b0, 16'd0);
        step(8'h08, 8'h08, 1'b0, 8'h08, 1'b0, 16'd0);
        step(8'h00, 8'h08, 1'b0, 8'h00, 1'b0, 16'd0);

        // Saturation on channel 7: nine pulses, overflow from the 8th
        for (int n = 1; n <= 9; n++)
            step(8'h80, 8'h00, 1'b0, 8'h80, (n >= 8), (n >= 8) ? 16'(n - 7) : 16'd0);
        // Count must be exactly 7: six acks keep request, the seventh clears it
        for (int j = 1; j <= 7; j++)
            step(8'h00, 8'h80, 1'b0, (j < 7) ? 8'h80 : 8'h00, 1'b1, 16'd2);

        // Reset clears overflow, then the priority-arbiter loop
        step(8'h00, 8'h00, 1'b1, 8'h00, 1'b0, 16'd0);
        step(8'hFF, 8'h00, 1'b0, 8'hFF, 1'b0, 16'd0);
        for (int k = 1; k <= 8; k++) begin
            ak = spikes_out & (~spikes_out + 8'd1);
            xs = 8'hFF << k;
            step(8'h00, ak, 1'b0, xs, 1'b0, 16'd0);
        end

        // Reset mid-operation with pending events and overflow set
        step(8'h03, 8'h00, 1'b0, 8'h03, 1'b0, 16'd0);
        for (int n = 1; n <= 8; n++)
            step(8'h80, 8'h00, 1'b0, 8'h83, (n >= 8), (n >= 8) ? 16'd1 : 16'd0);
        step(8'hFF, 8'h00, 1'b1, 8'h00, 1'b0, 16'd0);
        step(8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 16'd0);

        // Let the monitor drain the scoreboard, bounded
        wait_cnt = 0;
        while (sb_q.size() > 0 && wait_cnt < 10) begin
            @(posedge clk);
            wait_cnt++;
        end
        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain left=%0d exp=0", sb_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hidden_spike_buffer.md
Name: hidden_spike_buffer

Overview:
- Per-channel spike event buffer between the hidden layer and the output neuron's arbitrated `spikes_in` / `acks_out` interface.
- Each of N_CH channels counts hidden-neuron spike pulses into a saturating pending counter.
- A channel holds its request level high while events are pending.
- Each acknowledge consumes exactly one event, so no spike is lost while the downstream priority arbiter serves other channels.

Parameters:
- N_CH, 8: number of hidden channels; equals the downstream `spikes_in` width.
- CNT_W, 3: pending-counter width per channel; maximum pending events per channel = 2^CNT_W-1 (default 7).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- resetn  input  1  synchronous, active-high reset (asserted = 1 clears state on the next rising clk edge).
- spike_in  input  N_CH  single-cycle spike pulses from the hidden neurons; bit i = channel i event this cycle.
- acks_in  input  N_CH  acknowledge from the downstream arbiter; bit i consumes one channel-i event this cycle.
- spikes_out  output  N_CH  request levels to the downstream `spikes_in`; bit i = 1 iff count[i] != 0.
- pending_any  output  1  OR of `spikes_out`.
- overflow  output  1  sticky flag; set when any event is dropped because of saturation.

Behaviour:
- State:
  - count[i] is a CNT_W-bit register for each channel.
  - overflow is a 1-bit sticky register.
- Reset (resetn=1 at a rising edge):
  - all count[i]=0 and overflow=0, hence spikes_out=0 and pending_any=0.
  - Reset overrides all spike/ack activity that cycle.
  - Reset mid-operation discards all pending events without producing acks.
- Outputs are decoded combinationally from registered state only:
  - spikes_out[i] = (count[i] != 0).
  - No combinational path from spike_in or acks_in to any output.
  - This prevents a loop with the downstream combinational ack.
- Latency: spike_in[i] pulse at edge n makes spikes_out[i]=1 visible after edge n (one cycle), provided count was 0.
- Valid ack: valid_ack[i] = acks_in[i] & (count[i] != 0). An ack on an empty channel is ignored and causes no underflow.
- Per-channel update each rising edge (resetn=0):
  - spike=1, valid_ack=1: count unchanged (one event in, one out).
  - spike=1, valid_ack=0, count < max: count+1.
  - spike=1, valid_ack=0, count == max: count unchanged; event dropped; overflow <= 1.
  - spike=0, valid_ack=1: count-1.
  - spike=0, valid_ack=0: hold.
- Multiple ack bits in one cycle are legal. Each channel is handled independently.
- A request stays high until the counter drains to 0. It deasserts in the cycle after the edge that consumes the last event.
- overflow clears only by reset.
- pending_any = |spikes_out.
- No state machine beyond the per-channel up/down counters. Channels are fully independent; the block does no arbitration.

Optional Feature:
- Macro: HIDDEN_SPIKE_DROP_CNT_EN.
- Defined:
  - Adds output port drop_count (16 bits).
  - drop_count increments by the number of events dropped in that cycle, counting every saturated channel (0..N_CH per cycle).
  - drop_count saturates at 16'hFFFF and never wraps.
  - Reset value is 0.
  - overflow = (drop_count != 0) or the sticky flag; both give identical behaviour.
- Not defined:
  - drop_count port and its register are absent.
  - Only the sticky overflow flag exists.

Test Plan:
- Reset and single event:
  - Stimulus: resetn=1 for 2 cycles, then resetn=0, spike_in=8'h04 for one cycle, acks_in=0.
  - Response: spikes_out=8'h04 from the next cycle and held.
  - Then acks_in=8'h04 for one cycle -> spikes_out=8'h00 the cycle after; pending_any follows.
- Accumulate and drain:
  - Stimulus: three spike_in=8'h01 pulses, no acks.
  - Response: count[0]=3.
  - Then acks_in=8'h01 held -> spikes_out[0] stays 1 for exactly 3 ack cycles, then 0.
  - A further ack on the empty channel leaves count=0 with no underflow.
- Simultaneous spike and ack:
  - Stimulus: count[3]=1; spike_in=8'h08 and acks_in=8'h08 in the same cycle.
  - Response: count[3] stays 1 and spikes_out[3] stays 1.
- Saturation:
  - Stimulus: 9 consecutive spike_in=8'h80 cycles, no acks (CNT_W=3).
  - Response: count[7]=7; overflow=1 after the 8th pulse and stays 1.
  - With HIDDEN_SPIKE_DROP_CNT_EN defined: drop_count=2.
- Priority-arbiter loop:
  - Stimulus: spike_in=8'hFF once; acks_in driven by a model of the downstream lowest-index-first one-hot arbiter.
  - Response: spikes_out goes 8'hFF, 8'hFE, 8'hFC, ... 8'h80, 8'h00 over 8 consecutive cycles.
- Reset mid-operation:
  - Stimulus: several channels pending and overflow=1; assert resetn=1 for one cycle.
  - Response: next cycle spikes_out=0, overflow=0, and drop_count=0 if compiled in.
  - A spike in the reset cycle is discarded.
